// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the SRAM arbiter.
//   state_t      - arbiter FSM states
//   RAM_SEL_BIT  - request address bit that picks RAM1 (0) or RAM2 (1)
//   CNT_W        - width of the read-wait / write-pulse down-counter
//   STROBE_OFF   - inactive level of the active-low chip strobes
//   ADDR_ZERO    - address presented by an idle chip
package ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        FINISH
    } state_t;

    localparam int          RAM_SEL_BIT = 16;
    localparam int          CNT_W       = 4;
    localparam logic        STROBE_OFF  = 1'b1;
    localparam logic [17:0] ADDR_ZERO   = 18'd0;

    // Chip address pins carry two unused upper bits.
    function automatic logic [17:0] chip_addr(input logic [15:0] word);
        return {2'b00, word};
    endfunction

endpackage

// File: rtl/ram_chip_if.sv
// ram_chip_if: pin interface for one SRAM chip.
// Gates the arbiter's registered access commands with this chip's select
// so an unselected chip always shows idle strobes, a zero address and a
// released data bus.
//   sel            in   this chip is the target of the current access
//   en/oe/we/drv   in   registered access commands (active high)
//   addr, wdata    in   latched word address and write data
//   ram_addr       out  chip address pins
//   ram_en/oe/we   out  active-low chip strobes
//   ram_data       io   chip data bus
//   rd_data        out  current value on the data bus
module ram_chip_if
    import ram_pkg::*;
(
    input  logic        sel,
    input  logic        en,
    input  logic        oe,
    input  logic        we,
    input  logic        drv,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [17:0] ram_addr,
    output logic        ram_en,
    output logic        ram_oe,
    output logic        ram_we,
    inout  wire  [15:0] ram_data,
    output logic [15:0] rd_data
);

    logic act;

    assign act      = sel & en;
    assign ram_en   = act ? 1'b0 : STROBE_OFF;
    assign ram_oe   = (act & oe) ? 1'b0 : STROBE_OFF;
    assign ram_we   = (act & we) ? 1'b0 : STROBE_OFF;
    assign ram_addr = act ? chip_addr(addr) : ADDR_ZERO;

    // The FSM never raises drv and oe together, so the bus is released
    // whenever the chip may be driving it.
    assign ram_data = (sel & drv) ? wdata : {16{1'bz}};
    assign rd_data  = ram_data;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing two external 16-bit SRAMs
// between requester A (sequencer) and requester B (UART loader).
// Each grant runs one read or write strobe sequence on the chip chosen
// by address bit 16 and reports completion with a one-cycle done pulse.
//   clk, rst                   clock, synchronous active-high reset
//   req/we/addr/wdata_{a,b}    request fields, held until done
//   gnt_{a,b}, done_{a,b}      accept / completion pulses
//   rdata                      read data, held until the next read
//   busy                       high outside IDLE
//   ram_addr*/ram_data*/ram*EN/OE/WE  SRAM pins
//
// state    | meaning
// IDLE     | waiting; arbitrates and latches the winning request
// RD_ACC   | EN/OE low for RD_WAIT cycles, data sampled on last edge
// WR_SETUP | EN low, bus driven, WE still high
// WR_PULSE | WE low for WE_WIDTH cycles
// WR_HOLD  | WE high, bus still driven
// FINISH   | all strobes high, done pulse to the served port
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WE_WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        we_a,
    input  logic [16:0] addr_a,
    input  logic [15:0] wdata_a,
    input  logic        req_b,
    input  logic        we_b,
    input  logic [16:0] addr_b,
    input  logic [15:0] wdata_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [17:0] ram_addr1,
    output logic [17:0] ram_addr2,
    inout  wire  [15:0] ram_data1,
    inout  wire  [15:0] ram_data2,
    output logic        ram1EN,
    output logic        ram2EN,
    output logic        ram1OE,
    output logic        ram2OE,
    output logic        ram1WE,
    output logic        ram2WE
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_b;
    logic              port_b;
    logic [16:0]       lat_addr;
    logic [15:0]       lat_wdata;
    logic              cmd_en, cmd_oe, cmd_we, cmd_drv;
    logic              pick_b;
    logic [15:0]       rd1, rd2;

    // B wins when it is alone, or when both ask and A was served last.
    assign pick_b = req_b & (~req_a | ~last_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_b    <= 1'b1;
            port_b    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            cmd_en    <= 1'b0;
            cmd_oe    <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_drv   <= 1'b0;
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        port_b    <= pick_b;
                        last_b    <= pick_b;
                        gnt_a     <= ~pick_b;
                        gnt_b     <= pick_b;
                        lat_addr  <= pick_b ? addr_b : addr_a;
                        lat_wdata <= pick_b ? wdata_b : wdata_a;
                        busy      <= 1'b1;
                        cmd_en    <= 1'b1;
                        if (pick_b ? we_b : we_a) begin
                            state   <= WR_SETUP;
                            cmd_drv <= 1'b1;
                        end else begin
                            state  <= RD_ACC;
                            cmd_oe <= 1'b1;
                            cnt    <= CNT_W'(RD_WAIT - 1);
                        end
                    end
                end
                RD_ACC: begin
                    if (cnt == '0) begin
                        rdata  <= lat_addr[RAM_SEL_BIT] ? rd2 : rd1;
                        state  <= FINISH;
                        cmd_en <= 1'b0;
                        cmd_oe <= 1'b0;
                        done_a <= ~port_b;
                        done_b <= port_b;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    state  <= WR_PULSE;
                    cmd_we <= 1'b1;
                    cnt    <= CNT_W'(WE_WIDTH - 1);
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        state  <= WR_HOLD;
                        cmd_we <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    state   <= FINISH;
                    cmd_en  <= 1'b0;
                    cmd_drv <= 1'b0;
                    done_a  <= ~port_b;
                    done_b  <= port_b;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_chip_if u_chip1 (
        .sel      (~lat_addr[RAM_SEL_BIT]),
        .en       (cmd_en),
        .oe       (cmd_oe),
        .we       (cmd_we),
        .drv      (cmd_drv),
        .addr     (lat_addr[15:0]),
        .wdata    (lat_wdata),
        .ram_addr (ram_addr1),
        .ram_en   (ram1EN),
        .ram_oe   (ram1OE),
        .ram_we   (ram1WE),
        .ram_data (ram_data1),
        .rd_data  (rd1)
    );

    ram_chip_if u_chip2 (
        .sel      (lat_addr[RAM_SEL_BIT]),
        .en       (cmd_en),
        .oe       (cmd_oe),
        .we       (cmd_we),
        .drv      (cmd_drv),
        .addr     (lat_addr[15:0]),
        .wdata    (lat_wdata),
        .ram_addr (ram_addr2),
        .ram_en   (ram2EN),
        .ram_oe   (ram2OE),
        .ram_we   (ram2WE),
        .ram_data (ram_data2),
        .rd_data  (rd2)
    );

endmodule
